reg_file_sb: RTL and testbench

Parametrised integer register file with combinational read ports, one write-back port, optional write-to-read bypass and a per-register busy scoreboard. It sits between decode and write-back in the pipelined core. It supplies operands and hazard flags so the pipeline can stall on pending writes without a separate scoreboard block.

---
 rtl/reg_file_sb.sv | 80 ++++++++
 tb/tb_reg_file_sb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Integer register file with two combinational read ports, one write-back port,
// optional write-to-read forwarding and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic                      wr_ok, iss_ok;

  // Register 0 swallows both writes and issues when it is hardwired to zero.
  assign wr_ok  = we        && !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_ok = iss_valid && !((ZERO_REG != 0) && (iss_rd  == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Issue is applied after the write-back clear so a new producer on the same
  // register keeps it busy; flush cancels everything, including the issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[wr_addr] <= 1'b0;
      if (iss_ok) busy[iss_rd]  <= 1'b1;
    end
  end

  always_comb begin
    busy_vec = busy;
    if (ZERO_REG != 0) busy_vec[0] = 1'b0;
  end

  logic [1:0][AW-1:0]   raddr;
  logic [1:0][XLEN-1:0] rdata;
  logic [1:0]           rbusy;

  assign raddr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero, fwd;
    assign zero     = (ZERO_REG != 0) && (raddr[p] == '0);
    assign fwd      = (BYPASS != 0) && wr_ok && (wr_addr == raddr[p]);
    assign rdata[p] = zero ? '0 : (fwd ? wr_data : regs[raddr[p]]);
    assign rbusy[p] = !zero && busy[raddr[p]] && !fwd;
  end

  assign rs1_data = rdata[0];
  assign rs2_data = rdata[1];
  assign rs1_busy = rbusy[0];
  assign rs2_busy = rbusy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a forwarding instance and a non-forwarding
// instance share all inputs so same-cycle and next-cycle visibility can be compared.
module tb_reg_file_sb;
  localparam int XLEN = 32, NREG = 32, AW = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, iss_rd, wr_addr;
  logic            iss_valid, we, flush;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic            b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
  logic [NREG-1:0] b_busy_vec, n_busy_vec;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .busy_vec(b_busy_vec));

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .clk(clk), .reset_n(reset_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data), .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .busy_vec(n_busy_vec));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; we = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rs1_addr = '0; rs2_addr = '0; iss_rd = '0; wr_addr = '0;
    wr_data = '0; idle();
    #3;
    chk("rst_rs1_data", b_rs1_data, 32'h0);
    chk("rst_busy_vec", b_busy_vec, 32'h0);
    step();
    reset_n = 1'b1;
    rs1_addr = 5; rs2_addr = 5;
    #1;
    chk("post_rst_rs2_x5", b_rs2_data, 32'h0);

    // x5 write, then asynchronous reset mid-cycle
    step();
    we = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    #1;
    chk("byp_x5_same_cycle", b_rs1_data, 32'hDEADBEEF);
    chk("nobyp_x5_same_cycle", n_rs1_data, 32'h0);
    step();
    idle();
    #1;
    chk("nobyp_x5_next", n_rs1_data, 32'hDEADBEEF);
    reset_n = 1'b0;
    #1;
    chk("async_rst_x5", b_rs1_data, 32'h0);
    chk("async_rst_x5_nb", n_rs1_data, 32'h0);
    #1;
    reset_n = 1'b1;

    // register 0 ignores writes and issues
    step();
    we = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; iss_valid = 1'b1; iss_rd = 0;
    rs1_addr = 0; rs2_addr = 0;
    #1;
    chk("x0_byp_data", b_rs1_data, 32'h0);
    step();
    idle();
    #1;
    chk("x0_data", b_rs1_data, 32'h0);
    chk("x0_busy", {31'b0, b_rs1_busy}, 32'h0);
    chk("x0_busy_vec", b_busy_vec, 32'h0);

    // bypass: x7=0x11 then same-cycle write of 0x22
    we = 1'b1; wr_addr = 7; wr_data = 32'h11;
    step();
    wr_data = 32'h22; rs1_addr = 7; rs2_addr = 7;
    #1;
    chk("byp_rs1_x7", b_rs1_data, 32'h22);
    chk("byp_rs2_x7", b_rs2_data, 32'h22);
    chk("nobyp_rs1_x7", n_rs1_data, 32'h11);
    chk("nobyp_rs2_x7", n_rs2_data, 32'h11);
    step();
    idle();
    #1;
    chk("nobyp_rs1_x7_next", n_rs1_data, 32'h22);

    // scoreboard lifecycle on x3
    iss_valid = 1'b1; iss_rd = 3;
    step();
    idle(); rs1_addr = 3; rs2_addr = 3;
    #1;
    chk("sb_rs1_busy", {31'b0, b_rs1_busy}, 32'h1);
    chk("sb_rs2_busy", {31'b0, b_rs2_busy}, 32'h1);
    chk("sb_busy_vec", b_busy_vec, 32'h8);
    we = 1'b1; wr_addr = 3; wr_data = 32'h33;
    #1;
    chk("sb_byp_busy_drop", {31'b0, b_rs1_busy}, 32'h0);
    chk("sb_nobyp_busy_held", {31'b0, n_rs1_busy}, 32'h1);
    step();
    idle();
    #1;
    chk("sb_cleared_vec", b_busy_vec, 32'h0);
    chk("sb_x3_data", b_rs1_data, 32'h33);

    // simultaneous issue and write-back of x9
    iss_valid = 1'b1; iss_rd = 9;
    step();
    we = 1'b1; wr_addr = 9; wr_data = 32'h99;
    step();
    idle(); rs1_addr = 9;
    #1;
    chk("sim_busy_vec", b_busy_vec, 32'h200);
    chk("sim_x9_data", b_rs1_data, 32'h99);
    chk("sim_x9_busy", {31'b0, b_rs1_busy}, 32'h1);

    // issue x4 while writing back pending x6
    iss_valid = 1'b1; iss_rd = 6;
    step();
    iss_rd = 4; we = 1'b1; wr_addr = 6; wr_data = 32'h66;
    step();
    idle();
    #1;
    chk("x4_set_x6_clr", b_busy_vec, 32'h210);

    // flush cancels everything, including a same-cycle issue
    iss_valid = 1'b1; iss_rd = 1;
    step();
    iss_rd = 2;
    step();
    iss_rd = 3;
    step();
    #1;
    chk("pre_flush_vec", b_busy_vec, 32'h21E);
    flush = 1'b1; iss_rd = 10;
    step();
    idle(); rs1_addr = 3; rs2_addr = 9;
    #1;
    chk("flush_busy_vec", b_busy_vec, 32'h0);
    chk("flush_nb_busy_vec", n_busy_vec, 32'h0);
    chk("flush_x3_kept", b_rs1_data, 32'h33);
    chk("flush_x9_kept", b_rs2_data, 32'h99);
    rs1_addr = 6; rs2_addr = 7;
    #1;
    chk("flush_x6_kept", b_rs1_data, 32'h66);
    chk("flush_x7_kept", b_rs2_data, 32'h22);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
